// File: rtl/sram_sp_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port SRAM between NUM_REQ requesters.
// Optionally zero-fills the array after reset and returns read data to the issuing requester.
module sram_sp_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int SIZE      = 256,
  parameter int DATA_WD   = 32,
  parameter int RD_LAT    = 1,
  parameter int KNOB_INIT = 1,
  localparam int SIZE_WD  = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_val_i,
  input  logic [NUM_REQ-1:0]         req_wr_i,
  input  logic [NUM_REQ*SIZE_WD-1:0] req_adr_i,
  input  logic [NUM_REQ*DATA_WD-1:0] req_dat_i,
  output logic [NUM_REQ-1:0]         req_rdy_o,
  output logic [NUM_REQ-1:0]         rsp_val_o,
  output logic [DATA_WD-1:0]         rsp_dat_o,
  output logic [SIZE_WD-1:0]         sram_adr_o,
  output logic                       sram_wr_val_o,
  output logic [DATA_WD-1:0]         sram_wr_dat_o,
  output logic                       sram_rd_val_o,
  input  logic [DATA_WD-1:0]         sram_rd_dat_i,
  output logic                       init_busy_o
);

  localparam int IDX_WD = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ST_INIT, ST_SERV} state_e;

  typedef struct packed {
    logic              val;
    logic [IDX_WD-1:0] id;
  } rsp_ent_t;

  localparam state_e RST_STATE = (KNOB_INIT != 0) ? ST_INIT : ST_SERV;

  state_e             state_q, state_d;
  logic [SIZE_WD-1:0] init_cnt_q, init_cnt_d;
  logic [IDX_WD-1:0]  rr_ptr_q, rr_ptr_d;
  rsp_ent_t           rsp_pipe_q [RD_LAT];
  rsp_ent_t           rsp_in;

  logic              serving;
  logic              gnt_vld;
  logic [IDX_WD-1:0] gnt_idx;
  logic              gnt_wr;

  // Requester index reached by stepping 'off' places from 'base', wrapping at NUM_REQ.
  function automatic logic [IDX_WD-1:0] rr_slot(input logic [IDX_WD-1:0] base,
                                                input int unsigned       off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[IDX_WD-1:0];
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it
  // holding its old value and no latch is inferred.
  always_comb begin
    serving = !rst && (state_q == ST_SERV);
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (serving && !gnt_vld && req_val_i[rr_slot(rr_ptr_q, i)]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_slot(rr_ptr_q, i);
      end
    end
    gnt_wr = req_wr_i[gnt_idx];
  end

  // Init sweep owns the SRAM port; otherwise the granted requester drives it directly.
  always_comb begin
    req_rdy_o     = '0;
    sram_adr_o    = '0;
    sram_wr_val_o = 1'b0;
    sram_wr_dat_o = '0;
    sram_rd_val_o = 1'b0;
    init_busy_o   = 1'b0;
    if (!rst && state_q == ST_INIT) begin
      init_busy_o   = 1'b1;
      sram_wr_val_o = 1'b1;
      sram_adr_o    = init_cnt_q;
    end else if (gnt_vld) begin
      req_rdy_o[gnt_idx] = 1'b1;
      sram_adr_o         = req_adr_i[gnt_idx*SIZE_WD +: SIZE_WD];
      if (gnt_wr) begin
        sram_wr_val_o = 1'b1;
        sram_wr_dat_o = req_dat_i[gnt_idx*DATA_WD +: DATA_WD];
      end else begin
        sram_rd_val_o = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == SIZE_WD'(SIZE - 1)) state_d = ST_SERV;
    end
    if (gnt_vld) rr_ptr_d = (gnt_idx == IDX_WD'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    rsp_in.val = gnt_vld && !gnt_wr;
    rsp_in.id  = gnt_idx;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, which keeps the response shift register from collapsing into one stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST_STATE;
      init_cnt_q <= '0;
      rr_ptr_q   <= '0;
      for (int s = 0; s < RD_LAT; s++) rsp_pipe_q[s] <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      rsp_pipe_q[0] <= rsp_in;
      for (int s = 1; s < RD_LAT; s++) rsp_pipe_q[s] <= rsp_pipe_q[s-1];
    end
  end

  // Data is only passed through while a response is due, so idle SRAM output never leaks.
  always_comb begin
    rsp_val_o = '0;
    rsp_dat_o = '0;
    if (!rst && rsp_pipe_q[RD_LAT-1].val) begin
      rsp_val_o[rsp_pipe_q[RD_LAT-1].id] = 1'b1;
      rsp_dat_o                          = sram_rd_dat_i;
    end
  end

  if (NUM_REQ < 1 || RD_LAT < 1) begin : g_bad_param
    $error("sram_sp_arbiter: NUM_REQ and RD_LAT must both be >= 1");
  end

  if ((SIZE & (SIZE - 1)) != 0) begin : g_size_warn
    $warning("sram_sp_arbiter: SIZE is not a power of 2");
  end

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Bench for sram_sp_arbiter: RD_LAT=1 and RD_LAT=2 instances, each with an SRAM model and a
// per-cycle reference model, plus directed scenarios with literal expectations.
module tb_sram_sp_arbiter;

  localparam int NR = 2;
  localparam int SZ = 256;
  localparam int DW = 32;
  localparam int AW = 8;

  typedef struct {
    longint         due;
    int             id;
    logic [DW-1:0]  dat;
  } pend_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst         [2];
  logic [NR-1:0]    req_val     [2];
  logic [NR-1:0]    req_wr      [2];
  logic [NR*AW-1:0] req_adr     [2];
  logic [NR*DW-1:0] req_dat     [2];
  logic [NR-1:0]    req_rdy     [2];
  logic [NR-1:0]    rsp_val     [2];
  logic [DW-1:0]    rsp_dat     [2];
  logic [AW-1:0]    sram_adr    [2];
  logic             sram_wr_val [2];
  logic [DW-1:0]    sram_wr_dat [2];
  logic             sram_rd_val [2];
  logic [DW-1:0]    sram_rd_dat [2];
  logic             init_busy   [2];

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar u = 0; u < 2; u++) begin : g_u
    sram_sp_arbiter #(
      .NUM_REQ(NR), .SIZE(SZ), .DATA_WD(DW), .RD_LAT(u + 1), .KNOB_INIT(1)
    ) dut (
      .clk          (clk),
      .rst          (rst[u]),
      .req_val_i    (req_val[u]),
      .req_wr_i     (req_wr[u]),
      .req_adr_i    (req_adr[u]),
      .req_dat_i    (req_dat[u]),
      .req_rdy_o    (req_rdy[u]),
      .rsp_val_o    (rsp_val[u]),
      .rsp_dat_o    (rsp_dat[u]),
      .sram_adr_o   (sram_adr[u]),
      .sram_wr_val_o(sram_wr_val[u]),
      .sram_wr_dat_o(sram_wr_dat[u]),
      .sram_rd_val_o(sram_rd_val[u]),
      .sram_rd_dat_i(sram_rd_dat[u]),
      .init_busy_o  (init_busy[u])
    );

    // SRAM behavioural model: read data valid RD_LAT cycles after the read, X otherwise.
    logic [DW-1:0] mem    [SZ];
    logic [DW-1:0] sp_dat [u + 1];
    logic          sp_v   [u + 1];

    always @(posedge clk) begin
      if (sram_wr_val[u]) mem[sram_adr[u]] <= sram_wr_dat[u];
      sp_v[0]   <= sram_rd_val[u];
      sp_dat[0] <= mem[sram_adr[u]];
      for (int s = 1; s <= u; s++) begin
        sp_v[s]   <= sp_v[s-1];
        sp_dat[s] <= sp_dat[s-1];
      end
    end
    assign sram_rd_dat[u] = sp_v[u] ? sp_dat[u] : 'x;

    // Reference model: init countdown, round-robin pointer, expected memory, response queue.
    int            m_init_left = 0;
    int            m_ptr       = 0;
    longint        m_cyc       = 0;
    logic [DW-1:0] m_mem [SZ];
    pend_t         m_q [$];

    always @(negedge clk) begin : model
      logic [NR-1:0] e_rdy, e_rv;
      logic [AW-1:0] e_adr;
      logic [DW-1:0] e_wd, e_rd;
      logic          e_wv, e_rvl, e_busy;
      int            g;
      pend_t         p;
      e_rdy = '0; e_rv = '0; e_adr = '0; e_wd = '0; e_rd = '0;
      e_wv = 1'b0; e_rvl = 1'b0; e_busy = 1'b0; g = -1;
      if (!rst[u]) begin
        if (m_init_left > 0) begin
          e_busy = 1'b1;
          e_wv   = 1'b1;
          e_adr  = AW'(SZ - m_init_left);
        end else begin
          for (int i = 0; i < NR; i++)
            if (g < 0 && req_val[u][(m_ptr + i) % NR]) g = (m_ptr + i) % NR;
          if (g >= 0) begin
            e_rdy[g] = 1'b1;
            e_adr    = req_adr[u][g*AW +: AW];
            if (req_wr[u][g]) begin
              e_wv = 1'b1;
              e_wd = req_dat[u][g*DW +: DW];
            end else begin
              e_rvl = 1'b1;
            end
          end
        end
        if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
          e_rv[m_q[0].id] = 1'b1;
          e_rd            = m_q[0].dat;
          void'(m_q.pop_front());
        end
      end
      check($sformatf("u%0d_req_rdy", u),   req_rdy[u],     e_rdy);
      check($sformatf("u%0d_sram_adr", u),  sram_adr[u],    e_adr);
      check($sformatf("u%0d_sram_wv", u),   sram_wr_val[u], e_wv);
      check($sformatf("u%0d_sram_wd", u),   sram_wr_dat[u], e_wd);
      check($sformatf("u%0d_sram_rv", u),   sram_rd_val[u], e_rvl);
      check($sformatf("u%0d_init_busy", u), init_busy[u],   e_busy);
      check($sformatf("u%0d_rsp_val", u),   rsp_val[u],     e_rv);
      check($sformatf("u%0d_rsp_dat", u),   rsp_dat[u],     e_rd);
      if (rst[u]) begin
        m_init_left = SZ;
        m_ptr       = 0;
        m_q.delete();
      end else if (m_init_left > 0) begin
        m_mem[SZ - m_init_left] = '0;
        m_init_left--;
      end else if (g >= 0) begin
        m_ptr = (g + 1) % NR;
        if (e_wv) begin
          m_mem[e_adr] = e_wd;
        end else begin
          p.due = m_cyc + u + 1;
          p.id  = g;
          p.dat = m_mem[e_adr];
          m_q.push_back(p);
        end
      end
      m_cyc++;
    end
  end

  logic [NR-1:0] cap_rdy, cap_rv;
  logic [DW-1:0] cap_rd;
  logic [AW-1:0] cap_adr;
  logic          cap_busy, cap_wv;

  task automatic capture(input int u);
    cap_rdy  = req_rdy[u];
    cap_rv   = rsp_val[u];
    cap_rd   = rsp_dat[u];
    cap_adr  = sram_adr[u];
    cap_busy = init_busy[u];
    cap_wv   = sram_wr_val[u];
  endtask

  // Called just after a posedge; drives one cycle of inputs and samples at the negedge.
  task automatic step(input int u, input logic [1:0] v, input logic [1:0] w,
                      input logic [7:0] a0, input logic [7:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    req_val[u] = v;
    req_wr[u]  = w;
    req_adr[u] = {a1, a0};
    req_dat[u] = {d1, d0};
    @(negedge clk);
    capture(u);
    @(posedge clk);
    #1;
  endtask

  // Counts init_busy cycles (bounded); captures the first cycle; returns at the falling cycle's negedge.
  task automatic wait_init(input int u, output int n);
    n = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == 0) capture(u);
      if (!init_busy[u]) break;
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    logic [11:0]   seq12;
    logic [7:0]    seq8a, seq8b;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; req_val[u] = '0; req_wr[u] = '0; req_adr[u] = '0; req_dat[u] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    capture(0);
    check("rst_rdy", cap_rdy, 2'b00);
    check("rst_busy", cap_busy, 1'b0);
    check("rst_rsp_val", cap_rv, 2'b00);
    @(posedge clk);
    #1;

    // RD_LAT=1: init with both requesters already requesting reads of address 0.
    rst[0] = 1'b0;
    req_val[0] = 2'b11;
    wait_init(0, n);
    check("init_len", n, 256);
    check("init_first_adr", cap_adr, 8'h00);
    check("init_first_wv", cap_wv, 1'b1);
    check("init_first_rdy", cap_rdy, 2'b00);
    check("first_gnt", req_rdy[0], 2'b01);
    @(posedge clk);
    #1;

    step(0, 2'b01, 2'b01, 8'h05, 8'h00, 32'hA5A50001, 32'h0);
    check("wr5_gnt", cap_rdy, 2'b01);
    step(0, 2'b01, 2'b00, 8'h05, 8'h00, 32'h0, 32'h0);
    check("rd5_gnt", cap_rdy, 2'b01);
    check("rd5_no_rsp_yet", cap_rv, 2'b00);
    step(0, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    check("rd5_rsp_val", cap_rv, 2'b01);
    check("rd5_rsp_dat", cap_rd, 32'hA5A50001);
    step(0, 2'b01, 2'b00, 8'h7F, 8'h00, 32'h0, 32'h0);
    check("idle_rsp_dat", cap_rd, 32'h0);
    step(0, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    check("rd7f_rsp_val", cap_rv, 2'b01);
    check("rd7f_rsp_dat", cap_rd, 32'h0);

    step(0, 2'b10, 2'b00, 8'h00, 8'h05, 32'h0, 32'h0);
    check("req1_gnt", cap_rdy, 2'b10);
    seq8a = '0;
    seq8b = '0;
    for (int i = 0; i < 5; i++) begin
      step(0, (i < 4) ? 2'b11 : 2'b00, 2'b00, 8'h05, 8'h7F, 32'h0, 32'h0);
      if (i < 4) seq8a = {seq8a[5:0], cap_rdy};
      if (i > 0) seq8b = {seq8b[5:0], cap_rv};
      if (i == 1) check("alt_rsp_dat_req0", cap_rd, 32'hA5A50001);
      if (i == 2) check("alt_rsp_dat_req1", cap_rd, 32'h0);
    end
    check("alt_gnt_seq", seq8a, 8'b01_10_01_10);
    check("alt_rsp_seq", seq8b, 8'b01_10_01_10);

    seq12 = '0;
    for (int i = 0; i < 6; i++) begin
      step(0, (i < 3) ? 2'b10 : 2'b11, 2'b10, 8'h05, 8'(8'h20 + i), 32'h0,
           32'hBEEF0000 + 32'(i));
      seq12 = {seq12[9:0], cap_rdy};
    end
    check("rr_wrap_seq", seq12, 12'b10_10_10_01_10_01);
    step(0, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);

    // RD_LAT=2 instance.
    rst[1] = 1'b0;
    wait_init(1, n);
    check("l2_init_len", n, 256);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      step(1, 2'b01, 2'b01, 8'(i + 1), 8'h00, 32'(i + 1) * 32'h11, 32'h0);
      check($sformatf("l2_wr%0d_gnt", i + 1), cap_rdy, 2'b01);
    end
    seq12 = '0;
    for (int i = 0; i < 6; i++) begin
      step(1, (i < 3) ? 2'b01 : 2'b00, 2'b00, 8'(i + 1), 8'h00, 32'h0, 32'h0);
      seq12 = {seq12[9:0], cap_rv};
      if (i == 2) check("l2_rsp_dat1", cap_rd, 32'h11);
      if (i == 3) check("l2_rsp_dat2", cap_rd, 32'h22);
      if (i == 4) check("l2_rsp_dat3", cap_rd, 32'h33);
    end
    check("l2_rsp_seq", seq12, 12'b00_00_01_01_01_00);

    // Reset one cycle after a read accept: the response must never appear.
    step(1, 2'b01, 2'b00, 8'h01, 8'h00, 32'h0, 32'h0);
    check("kill_rd_gnt", cap_rdy, 2'b01);
    rst[1] = 1'b1;
    step(1, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    check("kill_rst_rsp_val", cap_rv, 2'b00);
    check("kill_rst_busy", cap_busy, 1'b0);
    rst[1] = 1'b0;
    req_val[1] = 2'b11;
    wait_init(1, n);
    check("kill_rsp_val", cap_rv, 2'b00);
    check("kill_init_adr0", cap_adr, 8'h00);
    check("kill_init_busy", cap_busy, 1'b1);
    check("kill_init_len", n, 256);
    check("kill_first_gnt", req_rdy[1], 2'b01);
    @(posedge clk);
    #1;
    step(1, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
